// File: rtl/amci_axi4lite_master.sv
// AXI4-Lite master engine driven by the AMCI request bus.
// Independent write and read FSMs; all status returned on AMCI_MISO is registered.
module amci_axi4lite_master #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32
) (
   input  logic                            CLK,
   input  logic                            RESETN,
   input  logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0] AMCI_MOSI,
   output logic [AXI_DATA_WIDTH+5:0]       AMCI_MISO,
   output logic [AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [AXI_ADDR_WIDTH-1:0]       M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0]       M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int A = AXI_ADDR_WIDTH;
   localparam int D = AXI_DATA_WIDTH;

   typedef struct packed {
      logic         read;
      logic         write;
      logic [A-1:0] raddr;
      logic [D-1:0] wdata;
      logic [A-1:0] waddr;
   } mosi_t;

   typedef struct packed {
      logic [1:0]   rresp;
      logic [1:0]   wresp;
      logic         ridle;
      logic         widle;
      logic [D-1:0] rdata;
   } miso_t;

   typedef enum logic [1:0] {
      W_IDLE, W_ADDR_DATA, W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE, R_ADDR, R_DATA
   } r_state_t;

   mosi_t req;
   miso_t sts;

   assign req       = AMCI_MOSI;
   assign AMCI_MISO = sts;

   w_state_t     w_state, w_state_d;
   logic         aw_valid, aw_valid_d;
   logic         w_valid, w_valid_d;
   logic         b_ready, b_ready_d;
   logic [A-1:0] aw_addr, aw_addr_d;
   logic [D-1:0] w_data, w_data_d;
   logic         w_idle, w_idle_d;
   logic [1:0]   w_resp, w_resp_d;

   r_state_t     r_state, r_state_d;
   logic         ar_valid, ar_valid_d;
   logic         r_ready, r_ready_d;
   logic [A-1:0] ar_addr, ar_addr_d;
   logic         r_idle, r_idle_d;
   logic [1:0]   r_resp, r_resp_d;
   logic [D-1:0] r_data, r_data_d;

   // A channel counts as done once its VALID is low or completes this edge.
   logic aw_done, w_done, b_hs, ar_hs, r_hs;

   assign aw_done = !aw_valid || M_AXI_AWREADY;
   assign w_done  = !w_valid || M_AXI_WREADY;
   assign b_hs    = b_ready && M_AXI_BVALID;
   assign ar_hs   = ar_valid && M_AXI_ARREADY;
   assign r_hs    = r_ready && M_AXI_RVALID;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         w_state  <= W_IDLE;
         aw_valid <= 1'b0;
         w_valid  <= 1'b0;
         b_ready  <= 1'b0;
         aw_addr  <= '0;
         w_data   <= '0;
         w_idle   <= 1'b1;
         w_resp   <= 2'b00;
      end else begin
         w_state  <= w_state_d;
         aw_valid <= aw_valid_d;
         w_valid  <= w_valid_d;
         b_ready  <= b_ready_d;
         aw_addr  <= aw_addr_d;
         w_data   <= w_data_d;
         w_idle   <= w_idle_d;
         w_resp   <= w_resp_d;
      end
   end

   always_comb begin
      w_state_d = w_state;
      unique case (w_state)
         W_IDLE:      if (req.write) w_state_d = W_ADDR_DATA;
         W_ADDR_DATA: if (aw_done && w_done) w_state_d = W_RESP;
         W_RESP:      if (b_hs) w_state_d = W_IDLE;
         default:     w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      aw_valid_d = aw_valid;
      w_valid_d  = w_valid;
      b_ready_d  = b_ready;
      aw_addr_d  = aw_addr;
      w_data_d   = w_data;
      w_idle_d   = w_idle;
      w_resp_d   = w_resp;
      unique case (w_state)
         W_IDLE: begin
            if (req.write) begin
               aw_addr_d  = req.waddr;
               w_data_d   = req.wdata;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               w_idle_d   = 1'b0;
            end
         end
         W_ADDR_DATA: begin
            if (aw_valid && M_AXI_AWREADY) aw_valid_d = 1'b0;
            if (w_valid && M_AXI_WREADY) w_valid_d = 1'b0;
            if (aw_done && w_done) b_ready_d = 1'b1;
         end
         W_RESP: begin
            if (b_hs) begin
               w_resp_d  = M_AXI_BRESP;
               b_ready_d = 1'b0;
               w_idle_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state  <= R_IDLE;
         ar_valid <= 1'b0;
         r_ready  <= 1'b0;
         ar_addr  <= '0;
         r_idle   <= 1'b1;
         r_resp   <= 2'b00;
         r_data   <= '0;
      end else begin
         r_state  <= r_state_d;
         ar_valid <= ar_valid_d;
         r_ready  <= r_ready_d;
         ar_addr  <= ar_addr_d;
         r_idle   <= r_idle_d;
         r_resp   <= r_resp_d;
         r_data   <= r_data_d;
      end
   end

   always_comb begin
      r_state_d = r_state;
      unique case (r_state)
         R_IDLE:  if (req.read) r_state_d = R_ADDR;
         R_ADDR:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (r_hs) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      ar_valid_d = ar_valid;
      r_ready_d  = r_ready;
      ar_addr_d  = ar_addr;
      r_idle_d   = r_idle;
      r_resp_d   = r_resp;
      r_data_d   = r_data;
      unique case (r_state)
         R_IDLE: begin
            if (req.read) begin
               ar_addr_d  = req.raddr;
               ar_valid_d = 1'b1;
               r_idle_d   = 1'b0;
            end
         end
         R_ADDR: begin
            if (ar_hs) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
            end
         end
         R_DATA: begin
            if (r_hs) begin
               r_data_d  = M_AXI_RDATA;
               r_resp_d  = M_AXI_RRESP;
               r_ready_d = 1'b0;
               r_idle_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign sts.rdata = r_data;
   assign sts.widle = w_idle;
   assign sts.ridle = r_idle;
   assign sts.wresp = w_resp;
   assign sts.rresp = r_resp;

   assign M_AXI_AWADDR  = aw_addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = aw_valid;
   assign M_AXI_WDATA   = w_data;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = w_valid;
   assign M_AXI_BREADY  = b_ready;
   assign M_AXI_ARADDR  = ar_addr;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = ar_valid;
   assign M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_amci_axi4lite_master.sv
// Bench for amci_axi4lite_master: directed scenarios plus a random AXI slave
// checked every cycle against a transaction-level model of the master.
module tb_amci_axi4lite_master;

   localparam int A = 32;
   localparam int D = 32;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RESETN;
   logic [A-1:0] waddr, raddr;
   logic [D-1:0] wdata;
   logic write, read;
   logic [2*A+D+1:0] mosi;
   logic [D+5:0] miso;

   assign mosi = {read, write, raddr, wdata, waddr};

   logic [A-1:0] awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, awready, wvalid, wready;
   logic [D-1:0] wdata_o;
   logic [D/8-1:0] wstrb;
   logic [1:0]   bresp, rresp;
   logic         bvalid, bready, arvalid, arready;
   logic [D-1:0] rdata;
   logic         rvalid, rready;

   wire [D-1:0] s_rdata = miso[D-1:0];
   wire         s_widle = miso[D];
   wire         s_ridle = miso[D+1];
   wire [1:0]   s_wresp = miso[D+3:D+2];
   wire [1:0]   s_rresp = miso[D+5:D+4];

   amci_axi4lite_master #(
      .AXI_DATA_WIDTH(D),
      .AXI_ADDR_WIDTH(A)
   ) dut (
      .CLK(CLK),
      .RESETN(RESETN),
      .AMCI_MOSI(mosi),
      .AMCI_MISO(miso),
      .M_AXI_AWADDR(awaddr),
      .M_AXI_AWPROT(awprot),
      .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata_o),
      .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp),
      .M_AXI_BVALID(bvalid),
      .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr),
      .M_AXI_ARPROT(arprot),
      .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata),
      .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready)
   );

   int n_chk = 0;
   int n_pass = 0;

   // transaction-level model of the master
   bit           m_wbusy, m_awp, m_wp;
   bit           m_rbusy, m_arp;
   logic [A-1:0] m_awaddr, m_araddr;
   logic [D-1:0] m_wdata, m_rdata;
   logic [1:0]   m_wresp, m_rresp;
   int           dut_aw_hs, dut_b_hs;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_wbusy  = 0; m_awp = 0; m_wp = 0;
      m_rbusy  = 0; m_arp = 0;
      m_awaddr = '0; m_araddr = '0;
      m_wdata  = '0; m_rdata  = '0;
      m_wresp  = '0; m_rresp  = '0;
   endtask

   // apply the protocol rules for the upcoming clock edge
   task automatic edge_model();
      bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
      if (awvalid && awready) dut_aw_hs++;
      if (bready && bvalid) dut_b_hs++;
      if (!RESETN) begin
         model_reset();
         return;
      end
      hs_aw = m_awp && awready;
      hs_w  = m_wp && wready;
      hs_b  = m_wbusy && !m_awp && !m_wp && bvalid;
      if (hs_aw) m_awp = 0;
      if (hs_w) m_wp = 0;
      if (hs_b) begin
         m_wbusy = 0;
         m_wresp = bresp;
      end else if (!m_wbusy && write) begin
         m_wbusy  = 1; m_awp = 1; m_wp = 1;
         m_awaddr = waddr;
         m_wdata  = wdata;
      end
      hs_ar = m_arp && arready;
      hs_r  = m_rbusy && !m_arp && rvalid;
      if (hs_ar) m_arp = 0;
      if (hs_r) begin
         m_rbusy = 0;
         m_rdata = rdata;
         m_rresp = rresp;
      end else if (!m_rbusy && read) begin
         m_rbusy  = 1; m_arp = 1;
         m_araddr = raddr;
      end
   endtask

   task automatic check_all();
      check("awvalid", 64'(awvalid), 64'(m_awp));
      check("wvalid", 64'(wvalid), 64'(m_wp));
      check("bready", 64'(bready), 64'(m_wbusy && !m_awp && !m_wp));
      check("arvalid", 64'(arvalid), 64'(m_arp));
      check("rready", 64'(rready), 64'(m_rbusy && !m_arp));
      check("widle", 64'(s_widle), 64'(!m_wbusy));
      check("ridle", 64'(s_ridle), 64'(!m_rbusy));
      check("wresp", 64'(s_wresp), 64'(m_wresp));
      check("rresp", 64'(s_rresp), 64'(m_rresp));
      check("rdata", 64'(s_rdata), 64'(m_rdata));
      if (m_awp) check("awaddr", 64'(awaddr), 64'(m_awaddr));
      if (m_wp) check("wdata", 64'(wdata_o), 64'(m_wdata));
      if (m_arp) check("araddr", 64'(araddr), 64'(m_araddr));
   endtask

   task automatic cycle();
      edge_model();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic slave_rand();
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = ($urandom_range(0, 2) == 0);
      bresp   = 2'($urandom);
      arready = 1'($urandom_range(0, 1));
      rvalid  = ($urandom_range(0, 2) == 0);
      rdata   = $urandom;
      rresp   = 2'($urandom);
   endtask

   initial begin
      RESETN = 1'b0;
      waddr = '0; wdata = '0; raddr = '0; write = 0; read = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 0;
      dut_aw_hs = 0; dut_b_hs = 0;
      model_reset();
      repeat (3) cycle();
      check("rst_awaddr", 64'(awaddr), 64'(0));
      check("rst_wdata", 64'(wdata_o), 64'(0));
      check("rst_araddr", 64'(araddr), 64'(0));
      check("awprot", 64'(awprot), 64'(0));
      check("arprot", 64'(arprot), 64'(0));
      check("wstrb", 64'(wstrb), 64'(4'hF));
      RESETN = 1'b1;

      // single write, slave always ready
      awready = 1; wready = 1; bvalid = 1; bresp = 0;
      waddr = 32'h1000; wdata = 32'hDEADBEEF; write = 1;
      cycle();
      write = 0;
      check("t1_awvalid", 64'(awvalid), 64'(1));
      check("t1_awaddr", 64'(awaddr), 64'(32'h1000));
      check("t1_wdata", 64'(wdata_o), 64'(32'hDEADBEEF));
      cycle();
      check("t1_bready", 64'(bready), 64'(1));
      cycle();
      check("t1_widle", 64'(s_widle), 64'(1));
      check("t1_wresp", 64'(s_wresp), 64'(0));

      // staggered AW / W handshakes
      bvalid = 0; awready = 1; wready = 0;
      waddr = 32'h1004; wdata = 32'hDEADBEEF; write = 1;
      cycle();
      write = 0;
      cycle();
      check("t2_awvalid", 64'(awvalid), 64'(0));
      check("t2_wvalid", 64'(wvalid), 64'(1));
      check("t2_wdata", 64'(wdata_o), 64'(32'hDEADBEEF));
      repeat (2) cycle();
      check("t2_bready_lo", 64'(bready), 64'(0));
      check("t2_widle_lo", 64'(s_widle), 64'(0));
      wready = 1;
      cycle();
      check("t2_bready", 64'(bready), 64'(1));
      bvalid = 1; bresp = 1;
      cycle();
      check("t2_widle", 64'(s_widle), 64'(1));
      check("t2_wresp", 64'(s_wresp), 64'(1));
      bvalid = 0;

      // read with error, early RVALID
      arready = 0; rvalid = 1; rdata = 32'h12345678; rresp = 2;
      raddr = 32'h2004; read = 1;
      cycle();
      read = 0; raddr = 32'hFFFF_0000;
      cycle();
      check("t3_araddr1", 64'(araddr), 64'(32'h2004));
      cycle();
      check("t3_araddr2", 64'(araddr), 64'(32'h2004));
      arready = 1;
      cycle();
      check("t3_rready", 64'(rready), 64'(1));
      cycle();
      check("t3_rdata", 64'(s_rdata), 64'(32'h12345678));
      check("t3_rresp", 64'(s_rresp), 64'(2));
      check("t3_ridle", 64'(s_ridle), 64'(1));
      rvalid = 0; arready = 0;

      // write request while busy is dropped
      awready = 0; wready = 0; bvalid = 0; bresp = 1;
      dut_aw_hs = 0; dut_b_hs = 0;
      waddr = 32'h100; wdata = 32'h1; write = 1;
      cycle();
      write = 0;
      cycle();
      waddr = 32'h3000; wdata = 32'h2; write = 1;
      cycle();
      write = 0; awready = 1; wready = 1;
      repeat (2) cycle();
      bvalid = 1;
      cycle();
      bvalid = 0;
      repeat (3) cycle();
      check("t4_aw_count", 64'(dut_aw_hs), 64'(1));
      check("t4_b_count", 64'(dut_b_hs), 64'(1));

      // concurrent write and read
      awready = 1; wready = 1; bvalid = 1; bresp = 3;
      arready = 1; rvalid = 1; rdata = 32'h55; rresp = 0;
      waddr = 32'h10; wdata = 32'hAA; raddr = 32'h20;
      write = 1; read = 1;
      cycle();
      write = 0; read = 0;
      check("t5_awvalid", 64'(awvalid), 64'(1));
      check("t5_wvalid", 64'(wvalid), 64'(1));
      check("t5_arvalid", 64'(arvalid), 64'(1));
      repeat (4) cycle();
      check("t5_widle", 64'(s_widle), 64'(1));
      check("t5_ridle", 64'(s_ridle), 64'(1));
      check("t5_rdata", 64'(s_rdata), 64'(32'h55));
      bvalid = 0; rvalid = 0;

      // reset while waiting for B
      waddr = 32'h40; wdata = 32'h4; write = 1;
      cycle();
      write = 0;
      cycle();
      check("t6_bready", 64'(bready), 64'(1));
      #2 RESETN = 1'b0;
      #1;
      check("t6_rst_bready", 64'(bready), 64'(0));
      check("t6_rst_awvalid", 64'(awvalid), 64'(0));
      check("t6_rst_wvalid", 64'(wvalid), 64'(0));
      check("t6_rst_widle", 64'(s_widle), 64'(1));
      check("t6_rst_wresp", 64'(s_wresp), 64'(0));
      check("t6_rst_rdata", 64'(s_rdata), 64'(0));
      model_reset();
      @(posedge CLK);
      #1;
      RESETN = 1'b1;
      bvalid = 1; bresp = 2;
      waddr = 32'h50; wdata = 32'h77; write = 1;
      cycle();
      write = 0;
      check("t6_awaddr", 64'(awaddr), 64'(32'h50));
      repeat (2) cycle();
      check("t6_widle", 64'(s_widle), 64'(1));
      check("t6_wresp", 64'(s_wresp), 64'(2));

      // random traffic against a random slave
      for (int i = 0; i < 2000; i++) begin
         write = ($urandom_range(0, 3) == 0);
         read  = ($urandom_range(0, 3) == 0);
         waddr = $urandom;
         wdata = $urandom;
         raddr = $urandom;
         slave_rand();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/amci_axi4lite_master.md
Name: amci_axi4lite_master

Overview:
- AXI4-Lite master engine that sits on the far end of the AMCI bus from a user controller.
- Accepts write and read requests on AMCI_MOSI and executes them as AXI4-Lite transactions on the M_AXI port.
- Returns idle flags, response codes and read data on AMCI_MISO.
- Write and read channels are fully independent and may run concurrently.

Parameters:
- AXI_DATA_WIDTH, 32: width of WDATA/RDATA and of the AMCI data fields.
- AXI_ADDR_WIDTH, 32: width of AWADDR/ARADDR and of the AMCI address fields.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- AMCI_MOSI  in  2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+2  request bus, packed from bit 0 upward:
  - waddr[A]
  - wdata[D]
  - raddr[A]
  - write[1]
  - read[1]
- AMCI_MISO  out  AXI_DATA_WIDTH+6  status bus, packed from bit 0 upward:
  - rdata[D]
  - widle[1]
  - ridle[1]
  - wresp[2]
  - rresp[2]
- M_AXI_AWADDR out A; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out D; M_AXI_WSTRB out D/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out A; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in D; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Clocking and reset: one clock (CLK). RESETN is asynchronous and active-low.
- Reset values:
  - All VALID/READY outputs 0.
  - AWADDR, WDATA, ARADDR = 0.
  - widle = 1, ridle = 1.
  - wresp = 0, rresp = 0, rdata = 0.
- Constant outputs: AWPROT = ARPROT = 3'b000. WSTRB = all ones.
- All MISO fields are registered, never combinational from AXI inputs.
- Write FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
  - W_IDLE: at an edge where write=1, latch waddr→AWADDR and wdata→WDATA, set AWVALID=1, WVALID=1, widle=0; go to W_ADDR_DATA.
  - W_IDLE: write is level-sampled; holding it high re-launches a new transaction on each return to idle.
  - W_ADDR_DATA: AW and W handshakes are tracked independently. AWVALID clears on the edge where AWVALID&AWREADY; WVALID clears on the edge where WVALID&WREADY. They may complete in either order or together.
  - W_ADDR_DATA → W_RESP: when both handshakes are done, set BREADY=1 and go to W_RESP.
  - W_RESP: on BVALID&BREADY, latch BRESP→wresp, clear BREADY, set widle=1; go to W_IDLE.
  - Minimum latency, slave always ready: request sampled at edge 0 → AW/W handshake at edge 1 → BREADY high after edge 1 → B handshake at edge 2 → widle=1 after edge 2.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: at an edge where read=1, latch raddr→ARADDR, set ARVALID=1, ridle=0; go to R_ADDR.
  - R_ADDR: on ARVALID&ARREADY, clear ARVALID, set RREADY=1; go to R_DATA.
  - R_DATA: on RVALID&RREADY, latch RDATA→rdata and RRESP→rresp, clear RREADY, set ridle=1; go to R_IDLE.
- Boundary conditions:
  - write/read asserted while the corresponding FSM is busy: ignored, no queueing.
  - Busy inputs: waddr/wdata/raddr changes have no effect once latched.
  - VALID stability: VALID, once asserted, is never dropped before its handshake. Address and data are held stable while VALID is high.
  - Simultaneous write and read requests: both start on the same edge with no interaction.
  - Result fields: wresp/rresp/rdata hold their last value until overwritten by the next completed transaction.
  - Error responses (SLVERR/DECERR): reported verbatim; no retry.
  - Reset mid-transaction: immediately returns to the reset values above. Slave-side cleanup is the system reset's responsibility.
  - BVALID/RVALID arriving early (before BREADY/RREADY): waits; accepted only in W_RESP/R_DATA.

Test Plan:
- Single write, slave always ready: waddr=0x1000, wdata=0xDEADBEEF, 1-cycle write pulse.
  - AWVALID=WVALID=1 one cycle with AWADDR=0x1000, WDATA=0xDEADBEEF.
  - BREADY next cycle; widle back to 1 within 3 cycles; wresp=0.
- Staggered write handshakes: AWREADY at cycle 1, WREADY delayed to cycle 4.
  - AWVALID drops after cycle 1; WVALID holds 0xDEADBEEF until cycle 4.
  - BREADY only after cycle 4; widle stays 0 until B handshake.
- Read with error: raddr=0x2004; slave ARREADY after 2 cycles, RDATA=0x12345678, RRESP=2.
  - ARADDR=0x2004 stable while ARVALID.
  - rdata=0x12345678, rresp=2, ridle=1 after R handshake.
- Request while busy: second write (0x3000) pulsed during an outstanding write.
  - No second AWVALID; only the first address appears on the bus; one B handshake total.
- Concurrent: write 0x10/0xAA and read 0x20 in the same cycle.
  - AWVALID, WVALID, ARVALID all rise together; both complete independently; widle=ridle=1 at end.
- Reset mid-write: assert RESETN=0 while in W_RESP.
  - BREADY, AWVALID, WVALID go 0 asynchronously; widle=1, wresp=0.
  - A subsequent write completes normally.
